mdu: RTL and testbench

//  Multi-cycle multiply/divide unit for the P6 pipelined MIPS core. It sits in EX beside the ALU.
//  It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the architectural HI/LO registers.

---
 rtl/mdu.sv | 151 +++++++++++++++
 tb/tb_mdu.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative-timed multiply/divide unit holding architectural HI/LO
// Result is computed at accept and held pending; busy counts down MULT_CYCLES/DIV_CYCLES before commit.

module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE_N  = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [31:0]    r_hi;
  logic [31:0]    r_lo;
  logic [63:0]    r_pend;
  logic           r_wr;

  state_t         w_state_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [31:0]    w_hi_nxt;
  logic [31:0]    w_lo_nxt;
  logic [63:0]    w_pend_nxt;
  logic           w_wr_nxt;

  logic [63:0]        w_smul;
  logic [63:0]        w_umul;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic signed [31:0] w_sdivisor;
  logic signed [31:0] w_squot;
  logic signed [31:0] w_srem;
  logic [31:0]        w_udivisor;
  logic [31:0]        w_uquot;
  logic [31:0]        w_urem;

  assign w_smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_umul = {32'b0, A} * {32'b0, B};

  // Dividing by 1 in the overflow case yields exactly 0x80000000 rem 0 without a trap.
  assign w_div_zero = (B == 32'd0);
  assign w_div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign w_sdivisor = (w_div_zero || w_div_ovf) ? 32'sd1 : $signed(B);
  assign w_squot    = $signed(A) / w_sdivisor;
  assign w_srem     = $signed(A) % w_sdivisor;
  assign w_udivisor = w_div_zero ? 32'd1 : B;
  assign w_uquot    = A / w_udivisor;
  assign w_urem     = A % w_udivisor;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_pend_nxt  = r_pend;
    w_wr_nxt    = r_wr;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (MDUOp)
            OP_MULT: begin
              w_pend_nxt  = w_smul;
              w_wr_nxt    = 1'b1;
              w_cnt_nxt   = MULT_N;
              w_state_nxt = S_BUSY;
            end
            OP_MULTU: begin
              w_pend_nxt  = w_umul;
              w_wr_nxt    = 1'b1;
              w_cnt_nxt   = MULT_N;
              w_state_nxt = S_BUSY;
            end
            OP_DIV: begin
              w_pend_nxt  = {w_srem, w_squot};
              w_wr_nxt    = !w_div_zero;
              w_cnt_nxt   = DIV_N;
              w_state_nxt = S_BUSY;
            end
            OP_DIVU: begin
              w_pend_nxt  = {w_urem, w_uquot};
              w_wr_nxt    = !w_div_zero;
              w_cnt_nxt   = DIV_N;
              w_state_nxt = S_BUSY;
            end
            OP_MTHI: w_hi_nxt = A;
            OP_MTLO: w_lo_nxt = A;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (r_cnt == ONE_N) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          if (r_wr) begin
            w_hi_nxt = r_pend[63:32];
            w_lo_nxt = r_pend[31:0];
          end
        end else begin
          w_cnt_nxt = r_cnt - ONE_N;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_pend  <= '0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_pend  <= w_pend_nxt;
      r_wr    <= w_wr_nxt;
    end
  end

  assign busy = (r_state == S_BUSY);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - randomized and directed bench for mdu against a behavioural HI/LO model

module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  MDUOp = 3'b000;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Architectural result of an op from its operands; bit 64 says whether HI/LO get written.
  function automatic logic [64:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    int      sa;
    int      sb;
    longint  p;
    longint  q;
    longint  rm;
    longint unsigned up;
    sa = a;
    sb = b;
    model_result = '0;
    case (op)
      OP_MULT: begin
        p = longint'(sa) * longint'(sb);
        model_result = {1'b1, p};
      end
      OP_MULTU: begin
        up = longint'({32'b0, a}) * longint'({32'b0, b});
        model_result = {1'b1, up};
      end
      OP_DIV: begin
        if (b != 0) begin
          q  = longint'(sa) / longint'(sb);
          rm = longint'(sa) % longint'(sb);
          model_result = {1'b1, rm[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b != 0) model_result = {1'b1, a % b, a / b};
      end
      default: ;
    endcase
  endfunction

  longint      ecount = 0;
  longint      m_end = 0;
  logic        m_busy = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [2:0]  m_op = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [64:0] m_r;

  always @(posedge clk) begin
    ecount++;
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0;
    end else if (m_busy) begin
      if (ecount == m_end) begin
        m_r = model_result(m_op, m_a, m_b);
        if (m_r[64]) begin
          m_hi = m_r[63:32];
          m_lo = m_r[31:0];
        end
        m_busy = 1'b0;
      end
    end else if (start) begin
      if (MDUOp inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
        m_busy = 1'b1;
        m_end  = ecount + ((MDUOp inside {OP_MULT, OP_MULTU}) ? MC : DC);
        m_op = MDUOp; m_a = A; m_b = B;
      end else if (MDUOp == OP_MTHI) begin
        m_hi = A;
      end else if (MDUOp == OP_MTLO) begin
        m_lo = A;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (busy !== m_busy || HI !== m_hi || LO !== m_lo) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t busy=%0b HI=%h LO=%h expected busy=%0b HI=%h LO=%h",
                 $time, busy, HI, LO, m_busy, m_hi, m_lo);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    reset = rst; start = st; MDUOp = op; A = a; B = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'($urandom), $urandom, $urandom);
  endtask

  // Drops start and scrambles operands until busy is seen low; returns busy cycles observed.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      reset = 1'b1; start = 1'b0; MDUOp = 3'($urandom); A = $urandom; B = $urandom;
      if (!busy) break;
      cycles++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       pick = 32'h8000_0000;
      1:       pick = 32'hFFFF_FFFF;
      2:       pick = 32'd0;
      3:       pick = 32'($urandom_range(0, 20));
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    int n;
    step(1'b0, 1'b0, OP_NOP, 0, 0);
    step(1'b0, 1'b0, OP_NOP, 0, 0);
    chk_en = 1'b1;
    step(1'b1, 1'b1, OP_MTHI, 32'hAAAA_5555, 0);
    step(1'b1, 1'b1, OP_MTLO, 32'h5555_AAAA, 0);
    step(1'b0, 1'b0, OP_NOP, 0, 0);
    step(1'b0, 1'b0, OP_NOP, 0, 0);
    step(1'b1, 1'b0, OP_NOP, 0, 0);
    lit("reset_hi", HI, 32'h0);
    lit("reset_lo", LO, 32'h0);
    lit("reset_busy", {31'b0, busy}, 32'h0);

    step(1'b1, 1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    lit("mult_busy_len", n, MC);
    lit("mult_hi", HI, 32'hFFFF_FFFF);
    lit("mult_lo", LO, 32'hFFFF_FFFA);
    step(1'b1, 1'b1, OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    lit("multu_busy_len", n, MC);
    lit("multu_hi", HI, 32'h0000_0002);
    lit("multu_lo", LO, 32'hFFFF_FFFA);

    step(1'b1, 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    lit("div_busy_len", n, DC);
    lit("div_lo", LO, 32'hFFFF_FFFD);
    lit("div_hi", HI, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, OP_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    lit("divu_lo", LO, 32'd3);
    lit("divu_hi", HI, 32'd1);

    step(1'b1, 1'b1, OP_MTHI, 32'h11, 0);
    step(1'b1, 1'b1, OP_MTLO, 32'h22, 0);
    step(1'b1, 1'b1, OP_DIV, 32'd99, 32'd0);
    wait_idle(n);
    lit("divzero_busy_len", n, DC);
    lit("divzero_hi", HI, 32'h11);
    lit("divzero_lo", LO, 32'h22);
    step(1'b1, 1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    lit("divovf_lo", LO, 32'h8000_0000);
    lit("divovf_hi", HI, 32'h0);

    step(1'b1, 1'b1, OP_MULT, 32'd3, 32'd4);
    step(1'b1, 1'b0, OP_NOP, 0, 0);
    step(1'b1, 1'b1, OP_MTLO, 32'h55, 0);
    wait_idle(n);
    lit("busy_ignore_lo", LO, 32'd12);
    lit("busy_ignore_hi", HI, 32'd0);

    step(1'b1, 1'b1, OP_MTHI, 32'h77, 0);
    step(1'b1, 1'b1, OP_MULT, 32'd5, 32'd7);
    step(1'b1, 1'b0, OP_NOP, 0, 0);
    step(1'b1, 1'b0, OP_NOP, 0, 0);
    step(1'b0, 1'b0, OP_NOP, 0, 0);
    step(1'b1, 1'b0, OP_NOP, 0, 0);
    lit("midreset_busy", {31'b0, busy}, 32'h0);
    lit("midreset_hi", HI, 32'h0);
    lit("midreset_lo", LO, 32'h0);
    idle(8);
    lit("midreset_late_hi", HI, 32'h0);
    lit("midreset_late_lo", LO, 32'h0);

    step(1'b1, 1'b1, OP_MTHI, 32'hDEAD_BEEF, 0);
    step(1'b1, 1'b0, OP_NOP, 0, 0);
    lit("mthi_hi", HI, 32'hDEAD_BEEF);
    lit("mthi_busy", {31'b0, busy}, 32'h0);
    step(1'b1, 1'b1, OP_MTLO, 32'h1234, 0);
    step(1'b1, 1'b0, OP_NOP, 0, 0);
    lit("mtlo_lo", LO, 32'h1234);

    for (int i = 0; i < 1500; i++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 2) != 0), 3'($urandom), pick(), b);
    end
    idle(DC + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
